round_robin_mux_n_1: RTL and testbench
======================================

Name: round_robin_mux_n_1

Overview:
Parametrised N:1 multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Arbitrates among requesting input channels, either round-robin or fixed-priority.
- Captures the granted channel's data into a one-entry output register and reports the source channel index.
- Sits between N producers and a single consumer. It is the sequential successor to the combinational 4:1/8:1 MUX blocks.

Parameters:
NUM_CHANNELS, 4, number of input channels; legal range >= 2.
DATA_WIDTH, 8, bits per channel.
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
SEL_WIDTH, derived localparam, $clog2(NUM_CHANNELS); not overridable.

Ports:
Clock_In  input  1  system clock; all state updates on rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Enable_In  input  1  when low, no new grants; a held output still drains.
Data_In  input  NUM_CHANNELS*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
Valid_In  input  NUM_CHANNELS  per-channel request.
Ready_Out  output  NUM_CHANNELS  per-channel accept; one-hot or zero.
Data_Out  output  DATA_WIDTH  registered selected data.
Channel_Out  output  SEL_WIDTH  index of the channel held in Data_Out.
Valid_Out  output  1  output register holds valid data.
Ready_In  input  1  consumer accept.

Behaviour:
- Interface: one clock, Clock_In. Reset_In is asynchronous and active-high.
- Reset values: Valid_Out=0, Data_Out=0, Channel_Out=0, internal Last_Grant=NUM_CHANNELS-1, so the first round-robin grant searches from channel 0.
- Output slot free: Slot_Free = !Valid_Out || Ready_In (combinational).
- Load condition: Load = Enable_In && |Valid_In && Slot_Free.
- Grant, ARB_MODE=1: first i with Valid_In[i]=1, searching Last_Grant+1, Last_Grant+2, ... modulo NUM_CHANNELS, with wrap from NUM_CHANNELS-1 to 0.
- Grant, ARB_MODE=0: lowest index with Valid_In[i]=1. Last_Grant is still updated but unused.
- Ready_Out: one-hot at the granted index when Load=1, else all zero. It is combinational from Valid_In, Enable_In, Valid_Out and Ready_In, and has no combinational path from Data_In.
- A transfer on channel i occurs in a cycle with Valid_In[i] && Ready_Out[i].
- On Load at the clock edge: Data_Out <= granted channel data; Channel_Out <= granted index; Valid_Out <= 1; Last_Grant <= granted index.
- Else if Ready_In: Valid_Out <= 0. Data_Out and Channel_Out hold their last values.
- Else: all state holds.
- Latency: input transfer to Valid_Out is 1 cycle.
- Throughput: one word per cycle sustained while Ready_In=1 and any Valid_In is high. Simultaneous drain and load in the same cycle gives back-to-back output with no bubble.
- Backpressure: Valid_Out=1 and Ready_In=0 means Ready_Out is all zero. Data_Out and Channel_Out are stable until accepted.
- Enable_In low: Ready_Out all zero. A held word still drains on Ready_In. Last_Grant holds.
- Single requester: it is granted every cycle regardless of Last_Grant.
- Requests withdrawn (Valid_In dropped with no transfer) have no effect on state.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous). A pending word is discarded. No transfer is counted on the reset cycle.
- Out of scope: X on Data_In of non-granted channels must not propagate to Data_Out.

Test Plan:
1. Reset, then all four Valid_In high with Ready_In=1 and ARB_MODE=1 -> Channel_Out sequence 0,1,2,3,0,... on consecutive cycles; Ready_Out sequence 0001,0010,0100,1000.
2. ARB_MODE=0, Valid_In=1010 held, Ready_In=1 -> Channel_Out=1 every cycle; channel 3 starves; Ready_Out=0010.
3. Channel 2 Data=0xA5 accepted, then Ready_In=0 for 3 cycles while Valid_In=1111 -> Valid_Out=1, Data_Out=0xA5, Channel_Out=2 stable; Ready_Out=0000. Ready_In back to 1 -> next grant is channel 3 with no bubble.
4. Enable_In=0 with Valid_In=1111 and one word held -> the held word drains when Ready_In=1; then Valid_Out=0 and Ready_Out=0000 until Enable_In=1. The first grant after re-enable follows Last_Grant.
5. Reset_In pulsed asynchronously between edges while Valid_Out=1 -> Valid_Out=0, Data_Out=0, Channel_Out=0 immediately. The first grant after release goes to channel 0 when all requesting.
6. NUM_CHANNELS=5, DATA_WIDTH=16, round-robin with random Valid_In and Ready_In for 200 cycles -> scoreboard matches a reference model. No request stays pending more than 5 consecutive grants while Ready_In=1. Ready_Out is always one-hot or zero.

Source files
------------

// File: rtl/round_robin_mux_n_1.sv
// N:1 arbitrated multiplexer with per-channel valid/ready handshakes and a
// one-entry registered output stage. It arbitrates round-robin or fixed
// priority, and reports the source channel alongside the captured word.
module round_robin_mux_n_1 #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ARB_MODE     = 1
) (
  input  logic                               Clock_In,
  input  logic                               Reset_In,
  input  logic                               Enable_In,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
  input  logic [NUM_CHANNELS-1:0]            Valid_In,
  output logic [NUM_CHANNELS-1:0]            Ready_Out,
  output logic [DATA_WIDTH-1:0]              Data_Out,
  output logic [$clog2(NUM_CHANNELS)-1:0]    Channel_Out,
  output logic                               Valid_Out,
  input  logic                               Ready_In
);

  localparam int SEL_WIDTH = $clog2(NUM_CHANNELS);
  localparam logic [SEL_WIDTH-1:0] LAST_GRANT_RST = SEL_WIDTH'(NUM_CHANNELS - 1);

  // Registered output stage and arbitration history
  logic [DATA_WIDTH-1:0] data_q,       data_d;
  logic [SEL_WIDTH-1:0]  chan_q,       chan_d;
  logic                  valid_q,      valid_d;
  logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;

  // Arbitration intermediates
  logic [NUM_CHANNELS-1:0] req_above;
  logic [NUM_CHANNELS-1:0] search_vec;
  logic [NUM_CHANNELS-1:0] grant_oh;
  logic [SEL_WIDTH-1:0]    grant_idx;
  logic                    grant_found;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic                    slot_free;
  logic                    load;

  // Grant selection. Round-robin is done by masking: requests strictly above
  // the last grant win first; when none exist the search wraps to the lowest
  // requesting index, which is equivalent to a modular scan from last+1.
  always_comb begin
    req_above = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      req_above[i] = Valid_In[i] && (i > 32'(last_grant_q));
    end

    if ((ARB_MODE != 0) && (|req_above)) begin
      search_vec = req_above;
    end else begin
      search_vec = Valid_In;
    end

    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (search_vec[i] && !grant_found) begin
        grant_oh[i] = 1'b1;
        grant_idx   = SEL_WIDTH'(i);
        grant_found = 1'b1;
      end
    end
  end

  // AND-OR data select: non-granted lanes are masked to zero, so unknowns
  // on idle channels never reach the output register.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      grant_data = grant_data |
                   (Data_In[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_oh[i]}});
    end
  end

  // Handshake: load when enabled, something requests and the slot can take it
  always_comb begin
    slot_free = !valid_q || Ready_In;
    load      = Enable_In && (|Valid_In) && slot_free;
    Ready_Out = load ? grant_oh : '0;
  end

  // Next state of the output register and arbitration history
  always_comb begin
    data_d       = data_q;
    chan_d       = chan_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      data_d       = grant_data;
      chan_d       = grant_idx;
      valid_d      = 1'b1;
      last_grant_d = grant_idx;
    end else if (Ready_In) begin
      valid_d = 1'b0;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      data_q       <= '0;
      chan_q       <= '0;
      valid_q      <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      data_q       <= data_d;
      chan_q       <= chan_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign Data_Out    = data_q;
  assign Channel_Out = chan_q;
  assign Valid_Out   = valid_q;

endmodule

// File: tb/tb_round_robin_mux_n_1.sv
// Self-checking bench for round_robin_mux_n_1: three instances (4ch RR,
// 4ch fixed priority, 5ch x 16b RR) compared every cycle against a
// behavioural model, plus directed checks for the handshake corner cases.
module tb_round_robin_mux_n_1;

  localparam int          NCH[3]   = '{4, 4, 5};
  localparam int          MODE[3]  = '{1, 0, 1};
  localparam logic [15:0] DMASK[3] = '{16'h00ff, 16'h00ff, 16'hffff};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // Stimulus per instance
  logic        en  [3];
  logic [4:0]  vin [3];
  logic        rdy [3];
  logic [15:0] din [3][5];

  // DUT nets
  logic [31:0] d0, d1;
  logic [79:0] d2;
  logic [3:0]  r0, r1;
  logic [4:0]  r2;
  logic [7:0]  q0, q1;
  logic [15:0] q2;
  logic [1:0]  c0, c1;
  logic [2:0]  c2;
  logic        vo0, vo1, vo2;

  // Observed outputs, normalised for the model
  logic [4:0]  o_ready [3];
  logic [15:0] o_data  [3];
  int          o_chan  [3];
  logic        o_valid [3];

  // Reference model state
  int          m_last  [3];
  logic        m_valid [3];
  logic [15:0] m_data  [3];
  int          m_chan  [3];

  int wait_cnt [5];
  int max_wait;

  always_comb begin
    d0 = '0;
    d1 = '0;
    d2 = '0;
    for (int c = 0; c < 4; c++) begin
      d0[c*8 +: 8] = din[0][c][7:0];
      d1[c*8 +: 8] = din[1][c][7:0];
    end
    for (int c = 0; c < 5; c++) d2[c*16 +: 16] = din[2][c];
  end

  always_comb begin
    o_ready[0] = {1'b0, r0};
    o_ready[1] = {1'b0, r1};
    o_ready[2] = r2;
    o_data[0]  = {8'h00, q0};
    o_data[1]  = {8'h00, q1};
    o_data[2]  = q2;
    o_chan[0]  = int'(c0);
    o_chan[1]  = int'(c1);
    o_chan[2]  = int'(c2);
    o_valid[0] = vo0;
    o_valid[1] = vo1;
    o_valid[2] = vo2;
  end

  round_robin_mux_n_1 #(.NUM_CHANNELS(4), .DATA_WIDTH(8), .ARB_MODE(1)) dut_rr4 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en[0]), .Data_In(d0),
    .Valid_In(vin[0][3:0]), .Ready_Out(r0), .Data_Out(q0), .Channel_Out(c0),
    .Valid_Out(vo0), .Ready_In(rdy[0]));

  round_robin_mux_n_1 #(.NUM_CHANNELS(4), .DATA_WIDTH(8), .ARB_MODE(0)) dut_fp4 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en[1]), .Data_In(d1),
    .Valid_In(vin[1][3:0]), .Ready_Out(r1), .Data_Out(q1), .Channel_Out(c1),
    .Valid_Out(vo1), .Ready_In(rdy[1]));

  round_robin_mux_n_1 #(.NUM_CHANNELS(5), .DATA_WIDTH(16), .ARB_MODE(1)) dut_rr5 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en[2]), .Data_In(d2),
    .Valid_In(vin[2]), .Ready_Out(r2), .Data_Out(q2), .Channel_Out(c2),
    .Valid_Out(vo2), .Ready_In(rdy[2]));

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel that would be granted now, or -1 if nobody requests
  function automatic int model_grant(input int id);
    int g = -1;
    if (MODE[id] == 0) begin
      for (int k = 0; k < NCH[id]; k++)
        if (g < 0 && vin[id][k]) g = k;
    end else begin
      for (int k = 1; k <= NCH[id]; k++) begin
        int idx;
        idx = (m_last[id] + k) % NCH[id];
        if (g < 0 && vin[id][idx]) g = idx;
      end
    end
    return g;
  endfunction

  function automatic bit model_load(input int id);
    return en[id] && (vin[id] != 0) && (!m_valid[id] || rdy[id]);
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 3; id++) begin
      m_valid[id] = 1'b0;
      m_data[id]  = '0;
      m_chan[id]  = 0;
      m_last[id]  = NCH[id] - 1;
    end
  endtask

  task automatic randomize_data();
    for (int id = 0; id < 3; id++)
      for (int c = 0; c < 5; c++)
        din[id][c] = 16'($urandom) & DMASK[id];
  endtask

  task automatic check_all();
    for (int id = 0; id < 3; id++) begin
      int   g;
      logic [4:0] exp_r;
      g     = model_grant(id);
      exp_r = (model_load(id) && g >= 0) ? (5'b00001 << g) : 5'b00000;
      check($sformatf("ready%0d", id), o_ready[id], exp_r);
      check($sformatf("valid%0d", id), o_valid[id], m_valid[id]);
      check($sformatf("data%0d", id),  o_data[id],  m_data[id]);
      check($sformatf("chan%0d", id),  o_chan[id],  m_chan[id]);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, re-drive data
  task automatic step();
    @(negedge clk);
    check_all();
    check("onehot2", $onehot0(o_ready[2]), 1);
    if (rdy[2]) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (!vin[2][ch] || o_ready[2][ch]) wait_cnt[ch] = 0;
        else if (o_ready[2] != 0) wait_cnt[ch]++;
        if (wait_cnt[ch] > max_wait) max_wait = wait_cnt[ch];
      end
    end
    @(posedge clk);
    for (int id = 0; id < 3; id++) begin
      int g;
      g = model_grant(id);
      if (model_load(id)) begin
        m_valid[id] = 1'b1;
        m_data[id]  = din[id][g];
        m_chan[id]  = g;
        m_last[id]  = g;
      end else if (rdy[id]) begin
        m_valid[id] = 1'b0;
      end
    end
    #1;
    randomize_data();
  endtask

  initial begin
    rst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      en[id] = 1'b0; vin[id] = '0; rdy[id] = 1'b0;
    end
    for (int c = 0; c < 5; c++) wait_cnt[c] = 0;
    max_wait = 0;
    randomize_data();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      check("rst_valid", o_valid[id], 0);
      check("rst_data",  o_data[id],  0);
      check("rst_chan",  o_chan[id],  0);
    end
    rst = 1'b0;

    // Round-robin rotation with all channels requesting
    en[0] = 1'b1; vin[0] = 5'b01111; rdy[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 check("t1_ready", o_ready[0], 5'b00001 << (k % 4));
      step();
      check("t1_chan", o_chan[0], k % 4);
    end

    // Fixed priority: channel 1 always wins over channel 3
    en[1] = 1'b1; vin[1] = 5'b01010; rdy[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check("t2_ready", o_ready[1], 5'b00010);
      step();
      check("t2_chan", o_chan[1], 1);
    end
    vin[1] = '0;

    // Backpressure holds a captured word, then resumes with no bubble
    vin[0] = 5'b00100; din[0][2] = 16'h00A5;
    step();
    vin[0] = 5'b01111; rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_ready", o_ready[0], 0);
      step();
      check("t3_valid", o_valid[0], 1);
      check("t3_data",  o_data[0],  16'h00A5);
      check("t3_chan",  o_chan[0],  2);
    end
    rdy[0] = 1'b1;
    #1 check("t3_next", o_ready[0], 5'b01000);
    step();
    check("t3_chan3", o_chan[0], 3);
    check("t3_nobubble", o_valid[0], 1);

    // Disable: held word drains, no new grants until re-enabled
    en[0] = 1'b0; rdy[0] = 1'b0;
    #1 check("t4_ready_hold", o_ready[0], 0);
    step();
    check("t4_held", o_valid[0], 1);
    rdy[0] = 1'b1;
    #1 check("t4_ready_drain", o_ready[0], 0);
    step();
    check("t4_drained", o_valid[0], 0);
    for (int k = 0; k < 2; k++) begin
      #1 check("t4_ready_off", o_ready[0], 0);
      step();
      check("t4_idle", o_valid[0], 0);
    end
    en[0] = 1'b1;
    #1 check("t4_reenable", o_ready[0], 5'b00001);
    step();
    check("t4_chan", o_chan[0], 0);

    // Asynchronous reset between edges while a word is held
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check("t5_valid", o_valid[0], 0);
    check("t5_data",  o_data[0],  0);
    check("t5_chan",  o_chan[0],  0);
    rst = 1'b0;
    model_reset();
    #1 check("t5_first", o_ready[0], 5'b00001);
    step();
    check("t5_chan0", o_chan[0], 0);

    // Randomised traffic on the five-channel instance
    vin[0] = '0;
    for (int c = 0; c < 5; c++) wait_cnt[c] = 0;
    max_wait = 0;
    for (int k = 0; k < 200; k++) begin
      vin[2] = 5'($urandom);
      rdy[2] = ($urandom_range(0, 3) != 0);
      en[2]  = ($urandom_range(0, 9) != 0);
      step();
    end
    check("t6_starve", (max_wait > 5) ? 1 : 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
